// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Power-up program loader for the instruction memory write port.
//   Consumes a byte stream made of a big-endian 32-bit word count followed by
//   that many big-endian 32-bit words. Each word is written to consecutive
//   instruction addresses starting at BASE_ADDR. The CPU is held in reset
//   (cpu_hold=1) until every word has landed in memory.
//
// Parameters
//   MEM_SIZE      instruction memory depth in words; largest legal count
//   BASE_ADDR     byte address of the first word (word aligned)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         1-cycle pulse, restarts a load from DONE or ERR
//   in_valid      in_data carries a byte
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   mem_we        1-cycle instruction memory write strobe
//   mem_addr      byte address of the write
//   mem_wdata     word written
//   cpu_hold      keep the CPU in reset while high
//   done          load completed successfully (level)
//   error         header count exceeded MEM_SIZE (level)
//   words_loaded  words written during the current load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned MEM_SIZE  = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [31:0] words_loaded
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned SHIFT_W  = DATA_W - BYTE_W;
    localparam logic [DATA_W-1:0] MEM_SIZE_W = DATA_W'(MEM_SIZE);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_FIN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t              state;
    logic [1:0]          byte_cnt;
    logic [SHIFT_W-1:0]  shift;
    logic [DATA_W-1:0]   count;

    // Byte handshake and the word that completes with the current byte.
    logic                accept_c;
    logic                last_byte_c;
    logic [DATA_W-1:0]   word_c;
    logic [DATA_W-1:0]   next_loaded_c;
    logic [DATA_W-1:0]   word_addr_c;

    always_comb begin
        accept_c      = in_valid && in_ready;
        last_byte_c   = (byte_cnt == 2'd3);
        word_c        = {shift, in_data};
        next_loaded_c = words_loaded + DATA_W'(1);
        word_addr_c   = BASE_ADDR + {words_loaded[DATA_W-3:0], 2'b00};
    end

    // Loader FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HDR;
            byte_cnt     <= 2'd0;
            shift        <= '0;
            count        <= '0;
            in_ready     <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;

            case (state)
                // Collect the 4-byte count and classify it.
                ST_HDR: begin
                    if (accept_c) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {shift[SHIFT_W-BYTE_W-1:0], in_data};
                        if (last_byte_c) begin
                            count <= word_c;
                            if (word_c == '0) begin
                                state    <= ST_FIN;
                                in_ready <= 1'b0;
                            end else if (word_c > MEM_SIZE_W) begin
                                state    <= ST_ERR;
                                in_ready <= 1'b0;
                                error    <= 1'b1;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                end

                // Assemble words; in_ready low here means the final strobe
                // is on the bus this cycle, so FIN follows.
                ST_DATA: begin
                    if (!in_ready) begin
                        state <= ST_FIN;
                    end else if (accept_c) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {shift[SHIFT_W-BYTE_W-1:0], in_data};
                        if (last_byte_c) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= word_addr_c;
                            mem_wdata    <= word_c;
                            words_loaded <= next_loaded_c;
                            if (next_loaded_c == count) begin
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end

                ST_FIN: begin
                    state    <= ST_DONE;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end

                // Terminal states; only start leaves them.
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state        <= ST_HDR;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_hold     <= 1'b1;
                        in_ready     <= 1'b1;
                        words_loaded <= '0;
                        byte_cnt     <= 2'd0;
                        count        <= '0;
                    end
                end

                default: begin
                    state    <= ST_HDR;
                    in_ready <= 1'b1;
                    byte_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed self-checking bench for imem_loader (MEM_SIZE=256, BASE_ADDR=0).
//   A negedge monitor logs every write strobe; scenario tasks drive bytes and
//   compare outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] wl;
    } strobe_t;

    strobe_t sq[$];
    int      cyc = 0;
    int      last_we_cyc = 0;
    int      done_rise_cyc = 0;
    logic    we_d = 1'b0;
    logic    done_d = 1'b0;
    logic    double_we = 1'b0;

    imem_loader #(.MEM_SIZE(256), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Strobe / done-edge logger, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            sq.push_back('{mem_addr, mem_wdata, words_loaded});
            last_we_cyc <= cyc;
            if (we_d) double_we <= 1'b1;
        end
        if (done && !done_d) done_rise_cyc <= cyc;
        we_d   <= mem_we;
        done_d <= done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (words_loaded !== 32'd0) begin n_bad++; $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); end
    endtask

    task automatic test_two_words();
        int n0;
        bit ok;
        n0 = sq.size();
        send_word(32'h0000_0002);
        send_word(32'h2008_0005);
        send_word(32'hAC08_0004);
        wait_done(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL two_done_timeout: got done=%b want 1", done); end
        n_cmp++; if (sq.size() - n0 !== 2) begin n_bad++; $display("FAIL two_strobe_count: got %0d want 2", sq.size() - n0); end
        if (sq.size() - n0 >= 2) begin
            n_cmp++; if (sq[n0].addr !== 32'h0) begin n_bad++; $display("FAIL two_addr0: got %h want 0", sq[n0].addr); end
            n_cmp++; if (sq[n0].data !== 32'h2008_0005) begin n_bad++; $display("FAIL two_data0: got %h want 20080005", sq[n0].data); end
            n_cmp++; if (sq[n0].wl !== 32'd1) begin n_bad++; $display("FAIL two_wl_at_strobe0: got %0d want 1", sq[n0].wl); end
            n_cmp++; if (sq[n0+1].addr !== 32'h4) begin n_bad++; $display("FAIL two_addr1: got %h want 4", sq[n0+1].addr); end
            n_cmp++; if (sq[n0+1].data !== 32'hAC08_0004) begin n_bad++; $display("FAIL two_data1: got %h want ac080004", sq[n0+1].data); end
        end
        n_cmp++; if (done_rise_cyc - last_we_cyc !== 2) begin n_bad++; $display("FAIL two_done_latency: got %0d want 2", done_rise_cyc - last_we_cyc); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL two_cpu_hold: got %b want 0", cpu_hold); end
        n_cmp++; if (words_loaded !== 32'd2) begin n_bad++; $display("FAIL two_words_loaded: got %0d want 2", words_loaded); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL two_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (mem_wdata !== 32'hAC08_0004) begin n_bad++; $display("FAIL two_wdata_hold: got %h want ac080004", mem_wdata); end
    endtask

    task automatic test_restart();
        pulse_start();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done: got %b want 0", done); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL restart_cpu_hold: got %b want 1", cpu_hold); end
        n_cmp++; if (words_loaded !== 32'd0) begin n_bad++; $display("FAIL restart_words_loaded: got %0d want 0", words_loaded); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL restart_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_error();
        int n0;
        n0 = sq.size();
        send_word(32'h0000_0101);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_error: got %b want 1", error); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL err_in_ready: got %b want 0", in_ready); end
        // Bytes offered while in ERR must be ignored.
        send_word(32'h1111_1111);
        settle();
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL err_cpu_hold: got %b want 1", cpu_hold); end
        n_cmp++; if (sq.size() !== n0) begin n_bad++; $display("FAIL err_no_strobe: got %0d want %0d", sq.size(), n0); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL err_done: got %b want 0", done); end
        pulse_start();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL err_restart_error: got %b want 0", error); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL err_restart_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_max_count();
        send_word(32'h0000_0100);
        tick();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL max_error: got %b want 0", error); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL max_in_ready: got %b want 1", in_ready); end
        pulse_rst();
    endtask

    task automatic test_zero_count();
        int n0;
        n0 = sq.size();
        send_word(32'h0000_0000);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_early: got %b want 0", done); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_in_ready: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL zero_cpu_hold: got %b want 0", cpu_hold); end
        settle();
        n_cmp++; if (sq.size() !== n0) begin n_bad++; $display("FAIL zero_no_strobe: got %0d want %0d", sq.size(), n0); end
    endtask

    task automatic test_toggle();
        int n0;
        bit ok;
        logic [31:0] w;
        pulse_start();
        n0 = sq.size();
        send_word(32'h0000_0001);
        w = 32'h1234_5678;
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            tick();
        end
        wait_done(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tog_done_timeout: got done=%b want 1", done); end
        n_cmp++; if (sq.size() - n0 !== 1) begin n_bad++; $display("FAIL tog_strobe_count: got %0d want 1", sq.size() - n0); end
        if (sq.size() - n0 >= 1) begin
            n_cmp++; if (sq[n0].data !== 32'h1234_5678) begin n_bad++; $display("FAIL tog_data: got %h want 12345678", sq[n0].data); end
            n_cmp++; if (sq[n0].addr !== 32'h0) begin n_bad++; $display("FAIL tog_addr: got %h want 0", sq[n0].addr); end
        end
    endtask

    task automatic test_reset_midload();
        int n0;
        bit ok;
        pulse_start();
        n0 = sq.size();
        send_word(32'h0000_0003);
        send_word(32'h1122_3344);
        // start during DATA has no effect.
        pulse_start();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_start_ignored: got in_ready=%b want 1", in_ready); end
        n_cmp++; if (words_loaded !== 32'd1) begin n_bad++; $display("FAIL mid_wl: got %0d want 1", words_loaded); end
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_rst();
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_rst_we: got %b want 0", mem_we); end
        n_cmp++; if (words_loaded !== 32'd0) begin n_bad++; $display("FAIL mid_rst_wl: got %0d want 0", words_loaded); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL mid_rst_wdata: got %h want 0", mem_wdata); end
        send_word(32'h0000_0001);
        send_word(32'hDEAD_BEEF);
        wait_done(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mid_done_timeout: got done=%b want 1", done); end
        n_cmp++; if (sq.size() - n0 !== 2) begin n_bad++; $display("FAIL mid_strobe_count: got %0d want 2", sq.size() - n0); end
        if (sq.size() - n0 >= 2) begin
            n_cmp++; if (sq[n0+1].addr !== 32'h0) begin n_bad++; $display("FAIL mid_addr: got %h want 0", sq[n0+1].addr); end
            n_cmp++; if (sq[n0+1].data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL mid_data: got %h want deadbeef", sq[n0+1].data); end
            n_cmp++; if (sq[n0+1].wl !== 32'd1) begin n_bad++; $display("FAIL mid_wl_new: got %0d want 1", sq[n0+1].wl); end
        end
        n_cmp++; if (double_we !== 1'b0) begin n_bad++; $display("FAIL strobe_width: got wide=%b want 0", double_we); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_restart();
        test_error();
        test_max_count();
        test_zero_count();
        test_toggle();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
